// File: rtl/i2s_pkg.sv
// Shared I2S constants and receiver FSM encoding.
// The transmitter uses the same frame geometry.
package i2s_pkg;
  localparam int unsigned I2S_WIDTH         = 16;
  localparam logic        I2S_CH_LEFT       = 1'b0;
  localparam logic        I2S_CH_RIGHT      = 1'b1;
  localparam int unsigned I2S_BITS_PER_HALF = 16;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } i2s_state_t;
endpackage

// File: rtl/i2s_receiver_if.sv
// Recovered-sample bus of the I2S receiver.
// The receiver drives the master side and the consumer reads the slave side.
interface i2s_receiver_if
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = I2S_WIDTH
) ();
  logic [WIDTH-1:0] sample_data;
  logic             sample_right;
  logic             sample_valid;
  logic [WIDTH-1:0] frame_left;
  logic [WIDTH-1:0] frame_right;
  logic             frame_valid;
  logic             short_word;

  modport master (
    output sample_data, sample_right, sample_valid,
    output frame_left, frame_right, frame_valid, short_word
  );

  modport slave (
    input sample_data, sample_right, sample_valid,
    input frame_left, frame_right, frame_valid, short_word
  );
endinterface

// File: rtl/i2s_sync_edge.sv
// N-stage synchroniser for one asynchronous input, with rising-edge detect
// on the synchronised value.
module i2s_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk48m,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk48m) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = chain[STAGES-1] & ~prev;
endmodule

// File: rtl/i2s_receiver.sv
// Slave-mode I2S receiver: oversamples sclk/lrclk/din on clk48m and recovers
// left/right words with per-word and per-frame strobes.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH       = I2S_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk48m,
  input  logic           rst,
  input  logic           sclk_in,
  input  logic           lrclk_in,
  input  logic           din,
  i2s_receiver_if.master rx
);
  localparam int unsigned      CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};

  logic sclk_s, sclk_rise, lr_s, din_s;
  logic lr_rise_unused, din_rise_unused;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk48m(clk48m), .rst(rst), .async_in(sclk_in), .sync_out(sclk_s), .rise(sclk_rise)
  );
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk48m(clk48m), .rst(rst), .async_in(lrclk_in), .sync_out(lr_s), .rise(lr_rise_unused)
  );
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk48m(clk48m), .rst(rst), .async_in(din), .sync_out(din_s), .rise(din_rise_unused)
  );

  i2s_state_t       state_q, state_d;
  logic             ws_prev_q, ws_prev_d, ws_seen_q, ws_seen_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, hold_q, hold_d;
  logic [CW-1:0]    count_q, count_d;
  logic             left_ok_q, left_ok_d;
  logic [WIDTH-1:0] sdata_q, sdata_d, fleft_q, fleft_d, fright_q, fright_d;
  logic             sright_q, sright_d, svalid_q, svalid_d;
  logic             fvalid_q, fvalid_d, short_q, short_d;
  logic [WIDTH-1:0] word;

  // Shifting past WIDTH yields an empty mask, which gives truncation for free.
  assign word = shreg_q | ({WIDTH{din_s}} & (MSB_ONE >> count_q));

  always_ff @(posedge clk48m) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ws_prev_q <= 1'b0;
      ws_seen_q <= 1'b0;
      shreg_q   <= '0;
      hold_q    <= '0;
      count_q   <= '0;
      left_ok_q <= 1'b0;
      sdata_q   <= '0;
      sright_q  <= 1'b0;
      svalid_q  <= 1'b0;
      fleft_q   <= '0;
      fright_q  <= '0;
      fvalid_q  <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ws_prev_q <= ws_prev_d;
      ws_seen_q <= ws_seen_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
      left_ok_q <= left_ok_d;
      sdata_q   <= sdata_d;
      sright_q  <= sright_d;
      svalid_q  <= svalid_d;
      fleft_q   <= fleft_d;
      fright_q  <= fright_d;
      fvalid_q  <= fvalid_d;
      short_q   <= short_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ws_prev_d = ws_prev_q;
    ws_seen_d = ws_seen_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    count_d   = count_q;
    left_ok_d = left_ok_q;
    sdata_d   = sdata_q;
    sright_d  = sright_q;
    fleft_d   = fleft_q;
    fright_d  = fright_q;
    svalid_d  = 1'b0;
    fvalid_d  = 1'b0;
    short_d   = 1'b0;
    if (sclk_rise) begin
      ws_prev_d = lr_s;
      ws_seen_d = 1'b1;
      case (state_q)
        // The first rise after reset only primes ws_prev, so a channel that is
        // already in progress at reset release is never mistaken for a new word.
        ST_IDLE: begin
          if (ws_seen_q && (lr_s != ws_prev_q)) begin
            state_d = ST_RUN;
            shreg_d = '0;
            count_d = '0;
          end
        end
        ST_RUN: begin
          if (lr_s == ws_prev_q) begin
            shreg_d = word;
            if (count_q != CNT_MAX) count_d = count_q + CW'(1);
          end else begin
            sdata_d  = word;
            sright_d = ws_prev_q;
            svalid_d = 1'b1;
            short_d  = (count_q < CNT_LAST);
            if (ws_prev_q == I2S_CH_LEFT) begin
              hold_d    = word;
              left_ok_d = 1'b1;
            end else if (left_ok_q) begin
              fleft_d   = hold_q;
              fright_d  = word;
              fvalid_d  = 1'b1;
              left_ok_d = 1'b0;
            end
            shreg_d = '0;
            count_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rx.sample_data  = sdata_q;
  assign rx.sample_right = sright_q;
  assign rx.sample_valid = svalid_q;
  assign rx.frame_left   = fleft_q;
  assign rx.frame_right  = fright_q;
  assign rx.frame_valid  = fvalid_q;
  assign rx.short_word   = short_q;
endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Slave-mode I2S receiver, clocked by clk48m. Oversamples externally driven sclk/lrclk/din, recovers left/right PCM words, and presents each word with a one-cycle valid strobe, plus a paired stereo frame.
- Feeds the synth's input/monitor path.
- Counterpart to the on-chip I2S transmitter, which it can be looped back against: 16-bit words, 16 sclk per lrclk half-period.

Parameters:
- WIDTH, 16, output word width in bits.
- SYNC_STAGES, 2, synchroniser flops per input (legal range 2..4).

Ports:
- clk48m  input  1  system clock, 48 MHz.
- rst  input  1  synchronous reset, active-high.
- sclk_in  input  1  external bit clock, asynchronous; must be at most clk48m/8.
- lrclk_in  input  1  external word select, asynchronous; 0 = left, 1 = right.
- din  input  1  serial data, MSB first.
- sample_data  output  WIDTH  most recent completed word.
- sample_right  output  1  channel of sample_data (1 = right).
- sample_valid  output  1  one-cycle strobe, sample_data/sample_right are new.
- frame_left  output  WIDTH  left word of the last complete stereo frame.
- frame_right  output  WIDTH  right word of the last complete stereo frame.
- frame_valid  output  1  one-cycle strobe; frame_left/frame_right are updated in the same cycle.
- short_word  output  1  one-cycle strobe; the completed word had fewer than WIDTH bits.

Behaviour:
- **Reset (rst=1 at a clk48m edge):**
  - All outputs go to 0.
  - Synchroniser chains, shift register, bit count and the left holding register are cleared.
  - FSM goes to IDLE.
  - Reset applied mid-word discards that word.
- **Input conditioning:**
  - sclk_in, lrclk_in and din each pass through SYNC_STAGES flops.
  - A rising sclk edge is detected when the synchronised sclk is 1 and its previous value was 0.
  - All sampling uses the synchronised din/lrclk taken in that same cycle.
- **Bit sampling (at each detected sclk rise):**
  - Sample bit b = din and word select ws = lrclk.
  - Compare ws with ws_prev, the ws captured at the previous sclk rise.
- **FSM, IDLE:**
  - Ignore data and update ws_prev.
  - On the first ws != ws_prev, go to RUN.
  - In that same cycle clear the shift register and set bit count = 0; the current bit is the LSB of a discarded partial word.
- **FSM, RUN, ws == ws_prev:**
  - If count < WIDTH, write b into shift-register position WIDTH-1-count.
  - Increment count, saturating at WIDTH+1.
  - Bits beyond WIDTH are discarded (truncation).
- **FSM, RUN, ws != ws_prev (standard I2S one-bit delay):**
  - b is the final bit of the word for channel ws_prev. Store it as above, then complete the word.
  - word = shift register after this store. Bits not received stay 0, so short words are left-justified.
  - On the next cycle (completion latency 1 cycle after the detected edge):
    - sample_data = word, sample_right = ws_prev, sample_valid = 1.
    - short_word = 1 if total bits < WIDTH.
  - If ws_prev = 0: latch word into the left holding register and set left_ok.
  - If ws_prev = 1 and left_ok: frame_left = holding register, frame_right = word, frame_valid = 1, then clear left_ok.
  - A right word without a preceding left word updates sample_* only.
  - Clear the shift register and set count = 0 for the new word.
- **End-to-end latency:** pin sclk rise → sample_valid ≤ SYNC_STAGES+2 clk48m cycles.
- **Strobe spacing:** strobes are never back-to-back, because sclk ≤ clk48m/8.
- **Simultaneous edges:** a lrclk change in the same synchronised cycle as an sclk rise is treated as the new ws at that rise.
- **Stalled sclk:** outputs hold and no strobes are produced.

Decomposition:
- Shared package i2s_pkg holds:
  - I2S_WIDTH = 16, I2S_CH_LEFT = 0, I2S_CH_RIGHT = 1.
  - FSM state encoding (IDLE, RUN).
  - The 16-sclk-per-half-frame constant shared with the transmitter.
- One sub-module: i2s_sync_edge, an N-stage synchroniser with rise detection, instantiated for sclk (rise used) and plain for lrclk/din.

Test Plan:
- **Loopback:** drive the on-chip transmitter with signal=16'hA5C3 and wire it to the receiver → after the first discarded partial word, every sample_valid shows 16'hA5C3; alternating sample_right; frame_valid with frame_left = frame_right = 16'hA5C3.
- **Bit-accurate BFM:** sclk = 1.5 MHz, left=16'h8001, right=16'h7FFE → sample_data 8001 (right=0) then 7FFE (right=1); frame_valid once per frame; short_word never asserted.
- **Short words:** 12 bits per half, left bits 0xABC → sample_data=16'hABC0 with short_word=1. Long words: 20 bits 0x12345 → 16'h1234, short_word=0.
- **Start mid-word:** release reset in the middle of a right word → that word is dropped (no sample_valid); the first strobe is the next left word; the first frame_valid follows the subsequent right word.
- **Reset mid-operation:** assert rst for one cycle after 8 bits of a left word → all outputs 0 the next cycle; no strobe for the interrupted word; normal operation resumes after the next lrclk edge.
- **Right-only / edge alignment:** lrclk toggling in the same synchronised cycle as sclk rise → the bit is assigned to the old word per the one-bit-delay rule; stalled sclk for 1000 cycles → no strobes, outputs stable.
